nn_dma_rd_arb: RTL and testbench
================================

// Module: nn_dma_rd_arb
// PURPOSE
//  Arbitrates the single 16-bit DMA read port between two burst requesters:
//  - the image-buffer fill path (IMG);
//  - the weight-memory fill path (WGT).
//  Each granted burst reads LEN consecutive DMA words starting at BASE.
//  Returned data is steered to the winning requester with a valid strobe and a done pulse.
//  Sits between nn_fsm's load sequencing and the external DMA read interface.
// PARAMETERS
//  DMA_ADDR_WIDTH  5   DMA word-address width; addresses wrap modulo 2**DMA_ADDR_WIDTH
//  LEN_WIDTH       6   burst-length width; LEN range 0..2**LEN_WIDTH-1
// PORTS
//  i_clk            in   1               clock
//  i_rst            in   1               synchronous reset, active-high
//  i_img_req        in   1               IMG burst request (level, held until o_img_gnt)
//  i_img_base_addr  in   DMA_ADDR_WIDTH  IMG burst start address
//  i_img_len        in   LEN_WIDTH       IMG burst length in words
//  o_img_gnt        out  1               1-cycle pulse: IMG burst accepted
//  o_img_vld        out  1               o_rd_data is an IMG word
//  o_img_done       out  1               1-cycle pulse: IMG burst complete
//  i_wgt_req        in   1               WGT burst request (level, held until o_wgt_gnt)
//  i_wgt_base_addr  in   DMA_ADDR_WIDTH  WGT burst start address
//  i_wgt_len        in   LEN_WIDTH       WGT burst length in words
//  o_wgt_gnt        out  1               1-cycle pulse: WGT burst accepted
//  o_wgt_vld        out  1               o_rd_data is a WGT word
//  o_wgt_done       out  1               1-cycle pulse: WGT burst complete
//  o_dma_rd_en      out  1               DMA read enable
//  o_dma_rd_addr    out  DMA_ADDR_WIDTH  DMA read address
//  i_dma_rd_data    in   16              DMA read data, valid 1 cycle after o_dma_rd_en
//  o_rd_data        out  16              i_dma_rd_data passed through, qualified by *_vld
//  o_busy           out  1               state != IDLE
// BEHAVIOUR
//  Reset:
//  - All outputs 0; state=IDLE; round-robin pointer favours IMG.
//  - Reset mid-burst aborts the burst: no further rd_en, vld or done; in-flight data is dropped.
//  States: IDLE, READ, DRAIN.
//  IDLE:
//  - Requests are sampled only in IDLE.
//  - Exactly one request: it wins.
//  - Both requests: the one not served last wins; pointer updates on each grant.
//  - At the edge ending IDLE cycle T, the winner's BASE, LEN and owner are latched.
//  Grant:
//  - In T+1, gnt=1 for exactly one cycle.
//  - Requester may drop req from T+2; parameter changes after T are ignored.
//  READ (LEN>0):
//  - Cycles T+1..T+LEN: rd_en=1, addr=BASE+k for k=0..LEN-1, wrapping modulo 2**DMA_ADDR_WIDTH.
//  - Reads are back-to-back with no bubbles; after the last read, go to DRAIN.
//  Data return:
//  - Owner's vld = rd_en delayed 1 cycle, i.e. cycles T+2..T+LEN+1.
//  - o_rd_data = i_dma_rd_data; the other requester's vld stays 0.
//  DRAIN:
//  - Single cycle T+LEN+1; owner's done=1 coincident with the last vld; then IDLE at T+LEN+2.
//  - Next grant pulse earliest at T+LEN+3.
//  LEN=0:
//  - Granted normally; gnt and done both pulse in T+1; no rd_en, no vld; IDLE at T+2.
//  - LEN=0 counts as service for round-robin.
//  Invariants:
//  - o_img_vld & o_wgt_vld never both 1.
//  - At most one burst in flight.
//  - rd_en is never 1 in IDLE or DRAIN.
//  - o_rd_data is don't-care when neither vld is set.
// TESTING
//  1. IMG only: base=3, len=4 -> rd_en 4 cycles, addr 3,4,5,6; img_vld next 4 cycles; img_done with 4th vld.
//  2. Both req same cycle after reset -> IMG granted first; WGT granted at earliest 2 cycles after img_done.
//  3. Continuous IMG+WGT, len=2 each -> grants alternate IMG,WGT,IMG,WGT; never two consecutive same owner.
//  4. Wrap: WGT base=30, len=5 (DMA_ADDR_WIDTH=5) -> addr 30,31,0,1,2; 5 wgt_vld; no img_vld.
//  5. LEN=0 IMG -> gnt and done same cycle; zero rd_en; busy 1 cycle; pointer now favours WGT.
//  6. i_rst asserted at 2nd read of len=8 -> all outputs 0 next cycle; no done; fresh req served normally.

Source files
------------

// File: rtl/nn_dma_rd_arb.sv
// nn_dma_rd_arb: two-requester burst arbiter for the shared DMA read port.
// Round-robin between image and weight fill paths, data steered to owner.
module nn_dma_rd_arb #(
  parameter int DMA_ADDR_WIDTH = 5,
  parameter int LEN_WIDTH      = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_img_req,
  input  logic [DMA_ADDR_WIDTH-1:0] i_img_base_addr,
  input  logic [LEN_WIDTH-1:0]      i_img_len,
  output logic                      o_img_gnt,
  output logic                      o_img_vld,
  output logic                      o_img_done,
  input  logic                      i_wgt_req,
  input  logic [DMA_ADDR_WIDTH-1:0] i_wgt_base_addr,
  input  logic [LEN_WIDTH-1:0]      i_wgt_len,
  output logic                      o_wgt_gnt,
  output logic                      o_wgt_vld,
  output logic                      o_wgt_done,
  output logic                      o_dma_rd_en,
  output logic [DMA_ADDR_WIDTH-1:0] o_dma_rd_addr,
  input  logic [15:0]               i_dma_rd_data,
  output logic [15:0]               o_rd_data,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;

  state_t                    state;
  state_t                    state_nxt;
  logic                      own_img;
  logic [DMA_ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]      len;
  logic [LEN_WIDTH-1:0]      cnt;
  logic                      prefer_img;
  logic                      gnt_q;
  logic                      rd_q;

  logic                      pick_any;
  logic                      pick_img;
  logic [LEN_WIDTH-1:0]      pick_len;
  logic [DMA_ADDR_WIDTH-1:0] pick_base;
  logic                      take;
  logic                      last_rd;
  logic                      rd_en;

  // Winner selection: a lone request wins, a tie goes to the favoured side.
  always_comb begin
    pick_any  = i_img_req | i_wgt_req;
    pick_img  = i_img_req & (~i_wgt_req | prefer_img);
    pick_len  = pick_img ? i_img_len : i_wgt_len;
    pick_base = pick_img ? i_img_base_addr : i_wgt_base_addr;
    take      = (state == IDLE) & pick_any;
    last_rd   = (cnt == (len - LEN_ONE));
    rd_en     = (state == READ);
  end

  // Next-state logic; zero-length bursts skip READ and finish in DRAIN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = (pick_len == LEN_ZERO) ? DRAIN : READ;
        end
      end
      READ: begin
        if (last_rd) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register, burst context latch and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      own_img    <= 1'b0;
      addr       <= '0;
      len        <= '0;
      cnt        <= '0;
      prefer_img <= 1'b1;
      gnt_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_q <= take;
      rd_q  <= rd_en;
      if (take) begin
        own_img    <= pick_img;
        addr       <= pick_base;
        len        <= pick_len;
        cnt        <= '0;
        prefer_img <= ~pick_img;
      end else if (rd_en) begin
        addr <= addr + 1'b1;
        cnt  <= cnt + LEN_ONE;
      end
    end
  end

  // Output steering; address and data are forced to zero when unqualified.
  always_comb begin
    o_dma_rd_en   = rd_en;
    o_dma_rd_addr = rd_en ? addr : '0;
    o_img_gnt     = gnt_q & own_img;
    o_wgt_gnt     = gnt_q & ~own_img;
    o_img_vld     = rd_q & own_img;
    o_wgt_vld     = rd_q & ~own_img;
    o_img_done    = (state == DRAIN) & own_img;
    o_wgt_done    = (state == DRAIN) & ~own_img;
    o_rd_data     = rd_q ? i_dma_rd_data : 16'h0000;
    o_busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_nn_dma_rd_arb.sv
// tb_nn_dma_rd_arb: randomized scoreboard bench for nn_dma_rd_arb.
// Expected grants, addresses and words are queued at issue time.
module tb_nn_dma_rd_arb;

  localparam int AW = 5;
  localparam int LW = 6;
  localparam int NA = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          img_req = 1'b0;
  logic [AW-1:0] img_base = '0;
  logic [LW-1:0] img_len = '0;
  logic          img_gnt, img_vld, img_done;
  logic          wgt_req = 1'b0;
  logic [AW-1:0] wgt_base = '0;
  logic [LW-1:0] wgt_len = '0;
  logic          wgt_gnt, wgt_vld, wgt_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   dma_data = '0;
  logic [15:0]   rd_data;
  logic          busy;

  nn_dma_rd_arb #(.DMA_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_img_req(img_req), .i_img_base_addr(img_base),
    .i_img_len(img_len), .o_img_gnt(img_gnt),
    .o_img_vld(img_vld), .o_img_done(img_done),
    .i_wgt_req(wgt_req), .i_wgt_base_addr(wgt_base),
    .i_wgt_len(wgt_len), .o_wgt_gnt(wgt_gnt),
    .o_wgt_vld(wgt_vld), .o_wgt_done(wgt_done),
    .o_dma_rd_en(rd_en), .o_dma_rd_addr(rd_addr),
    .i_dma_rd_data(dma_data), .o_rd_data(rd_data),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [NA];

  // DMA memory: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (rd_en) dma_data <= mem[rd_addr];
    else dma_data <= 16'($urandom);
  end

  typedef struct {
    bit img;
    int len;
  } gnt_t;

  typedef struct {
    bit          img;
    logic [15:0] d;
    bit          last;
    bit          zero;
  } word_t;

  gnt_t  gq[$];
  word_t wq[$];
  int    aq[$];

  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  bit  prev_done = 1'b0;
  bit  favor_img = 1'b1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic push_burst(bit img, int base, int len);
    gnt_t  g;
    word_t w;
    g.img = img;
    g.len = len;
    gq.push_back(g);
    for (int k = 0; k < len; k++) begin
      aq.push_back((base + k) % NA);
      w.img  = img;
      w.d    = mem[(base + k) % NA];
      w.last = (k == len - 1);
      w.zero = 1'b0;
      wq.push_back(w);
    end
    if (len == 0) begin
      w.img  = img;
      w.d    = '0;
      w.last = 1'b1;
      w.zero = 1'b1;
      wq.push_back(w);
    end
  endtask

  // Monitor: every DUT event is checked against the queue heads.
  always @(negedge clk) begin
    if (mon_en) begin
      gnt_t  g;
      word_t w;
      bit    dn;
      dn = img_done | wgt_done;
      if (img_vld && wgt_vld) chk("both_vld", 1, 0);
      if (img_done && wgt_done) chk("both_done", 1, 0);
      if (img_gnt || wgt_gnt) begin
        if (img_gnt && wgt_gnt) chk("both_gnt", 1, 0);
        if (prev_done) chk("gnt_spacing", 1, 0);
        if (gq.size() == 0) chk("unexpected_gnt", 1, 0);
        else begin
          g = gq.pop_front();
          chk("gnt_owner", {31'd0, img_gnt}, {31'd0, g.img});
          chk("first_read", {31'd0, rd_en}, {31'd0, g.len > 0});
          chk("gnt_busy", {31'd0, busy}, 1);
        end
      end
      if (rd_en) begin
        if (aq.size() == 0) chk("unexpected_rd", 1, 0);
        else chk("rd_addr", {27'd0, rd_addr}, aq.pop_front());
        chk("rd_busy", {31'd0, busy}, 1);
      end
      if (img_vld || wgt_vld) begin
        if (wq.size() == 0) chk("unexpected_vld", 1, 0);
        else begin
          w = wq.pop_front();
          chk("vld_zero", {31'd0, w.zero}, 0);
          chk("vld_owner", {31'd0, img_vld}, {31'd0, w.img});
          chk("rd_data", {16'd0, rd_data}, {16'd0, w.d});
          chk("done_last", {31'd0, dn}, {31'd0, w.last});
          if (dn) chk("done_owner", {31'd0, img_done}, {31'd0, w.img});
        end
      end else if (dn) begin
        if (wq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          w = wq.pop_front();
          chk("done_zero", {31'd0, w.zero}, 1);
          chk("done_owner0", {31'd0, img_done}, {31'd0, w.img});
          chk("zero_gnt", {31'd0, img_gnt | wgt_gnt}, 1);
        end
      end
      prev_done = dn;
    end
  end

  task automatic do_round(bit ri, bit rw, int bi, int li, int bw, int lw);
    bit pi, pw, first_img;
    int cyc;
    if (ri && rw) first_img = favor_img;
    else first_img = ri;
    if (ri && rw) begin
      if (first_img) begin
        push_burst(1, bi, li);
        push_burst(0, bw, lw);
      end else begin
        push_burst(0, bw, lw);
        push_burst(1, bi, li);
      end
      favor_img = first_img;
    end else if (ri) begin
      push_burst(1, bi, li);
      favor_img = 1'b0;
    end else if (rw) begin
      push_burst(0, bw, lw);
      favor_img = 1'b1;
    end
    @(negedge clk);
    img_base = AW'(bi);
    img_len  = LW'(li);
    wgt_base = AW'(bw);
    wgt_len  = LW'(lw);
    img_req  = ri;
    wgt_req  = rw;
    pi = ri;
    pw = rw;
    cyc = 0;
    while ((pi || pw) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (pi && img_gnt) begin
        img_req  = 1'b0;
        img_base = AW'($urandom);
        img_len  = LW'($urandom);
        pi = 1'b0;
      end
      if (pw && wgt_gnt) begin
        wgt_req  = 1'b0;
        wgt_base = AW'($urandom);
        wgt_len  = LW'($urandom);
        pw = 1'b0;
      end
    end
    if (pi || pw) begin
      chk("gnt_timeout", 1, 0);
      img_req = 1'b0;
      wgt_req = 1'b0;
    end
    cyc = 0;
    while ((busy || wq.size() != 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("drain_timeout", 1, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic int rlen();
    if ($urandom_range(0, 7) == 0) return $urandom_range(0, 63);
    return $urandom_range(0, 6);
  endfunction

  task automatic chk_quiet(string name);
    chk({name, "_rd_en"}, {31'd0, rd_en}, 0);
    chk({name, "_addr"}, {27'd0, rd_addr}, 0);
    chk({name, "_vld"}, {30'd0, img_vld, wgt_vld}, 0);
    chk({name, "_done"}, {30'd0, img_done, wgt_done}, 0);
    chk({name, "_gnt"}, {30'd0, img_gnt, wgt_gnt}, 0);
    chk({name, "_busy"}, {31'd0, busy}, 0);
    chk({name, "_data"}, {16'd0, rd_data}, 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < NA; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");
    mon_en = 1'b1;

    do_round(1, 1, 7, 3, 12, 2);
    do_round(1, 0, 3, 4, 0, 0);
    do_round(0, 1, 0, 0, 30, 5);
    do_round(1, 0, 9, 0, 0, 0);
    do_round(1, 1, 1, 2, 17, 3);
    for (int i = 0; i < 4; i++)
      do_round(1, 1, $urandom_range(0, 31), 2,
               $urandom_range(0, 31), 2);

    mon_en = 1'b0;
    @(negedge clk);
    img_base = AW'(5);
    img_len  = LW'(8);
    img_req  = 1'b1;
    cyc = 0;
    while (!img_gnt && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_test_gnt", {31'd0, img_gnt}, 1);
    img_req = 1'b0;
    @(negedge clk);
    chk("rst_test_2nd_rd", {31'd0, rd_en}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("mid_rst");
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle",
          {27'd0, rd_en, img_vld, wgt_vld, img_done, wgt_done}, 0);
    end
    favor_img = 1'b1;
    prev_done = 1'b0;
    mon_en = 1'b1;
    do_round(1, 1, 20, 3, 4, 1);

    for (int i = 0; i < 150; i++)
      do_round($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 31), rlen(),
               $urandom_range(0, 31), rlen());

    chk("left_gnt", gq.size(), 0);
    chk("left_addr", aq.size(), 0);
    chk("left_words", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
